// File: rtl/systolic_seq.sv
// -----------------------------------------------------------------------------
// systolic_seq
//
// Command sequencer for a 2x2 systolic multiply array. For one accepted
// command of length K it:
//   1. streams four K-word vectors out of a word buffer (A row 0, A row 1,
//      B col 0, B col 1) and presents each word to the array with the
//      matching write enable one cycle after the buffer read,
//   2. pulses start for one cycle,
//   3. waits for every PE to report completion on se (first report wins),
//      or gives up after TMO cycles,
//   4. writes the four PE results back to the buffer,
//   5. pulses done.
//
// Parameters
//   ADR_W   buffer word-address width (addresses wrap modulo 2^ADR_W)
//   TMO     watchdog limit, in cycles spent in WAIT (must be >= 1)
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_len                         vector length K (0 is rejected)
//   cmd_abase/cmd_bbase/cmd_sbase   A source, B source, result bases
//   buf_ren/buf_radr/buf_rdata      buffer read port, data one cycle later
//   buf_wen/buf_wadr/buf_wdata      buffer write port
//   a_in0/a_in1/b_in0/b_in1         array operand inputs (same word on all)
//   awe0/awe1/bwe0/bwe1             per-row/column operand write enables
//   start, max_cntr                 array start pulse and run length
//   se, sat, s_out                  per-PE done, saturation and result,
//                                   ordered {PE1_1,PE0_1,PE1_0,PE0_0}
//   busy, done                      activity flag and completion pulse
//   err_len, err_sat, err_tmo       K=0, saturation seen, watchdog fired
// -----------------------------------------------------------------------------
module systolic_seq #(
  parameter int ADR_W = 12,
  parameter int TMO   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_len,
  input  logic [ADR_W-1:0] cmd_abase,
  input  logic [ADR_W-1:0] cmd_bbase,
  input  logic [ADR_W-1:0] cmd_sbase,
  output logic             buf_ren,
  output logic [ADR_W-1:0] buf_radr,
  input  logic [15:0]      buf_rdata,
  output logic             buf_wen,
  output logic [ADR_W-1:0] buf_wadr,
  output logic [15:0]      buf_wdata,
  output logic [15:0]      a_in0,
  output logic [15:0]      a_in1,
  output logic [15:0]      b_in0,
  output logic [15:0]      b_in1,
  output logic             awe0,
  output logic             awe1,
  output logic             bwe0,
  output logic             bwe1,
  output logic             start,
  output logic [7:0]       max_cntr,
  input  logic [3:0]       se,
  input  logic [3:0]       sat,
  input  logic [63:0]      s_out,
  output logic             busy,
  output logic             done,
  output logic             err_len,
  output logic             err_sat,
  output logic             err_tmo
);

  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  typedef enum logic [3:0] {
    IDLE, LD_A0, LD_A1, LD_B0, LD_B1, FLUSH, START, WAIT, STORE, DONE
  } state_t;

  state_t           state;
  logic [7:0]       idx;        // word index within the current load/store phase
  logic [7:0]       k;          // latched vector length
  logic [ADR_W-1:0] abase;
  logic [ADR_W-1:0] bbase;
  logic [ADR_W-1:0] sbase;
  logic [TW-1:0]    wcnt;       // cycles already spent in WAIT
  logic [3:0]       cap_flag;   // PE result captured (sticky)
  logic [3:0]       cap_sat;    // saturation bit captured with the result
  logic [15:0]      cap_val [4];

  logic [3:0]       flag_n;
  logic [3:0]       sat_n;
  logic [15:0]      word_n [4];
  logic [ADR_W-1:0] k_adr;
  logic [15:0]      op_data;

  assign k_adr = ADR_W'(k);

  // Capture view including this cycle's se, so a PE reporting on the same
  // edge WAIT is left is already counted and its result already usable.
  always_comb begin
    flag_n = cap_flag | se;
    for (int i = 0; i < 4; i++) begin
      if (cap_flag[i]) begin
        word_n[i] = cap_val[i];
        sat_n[i]  = cap_sat[i];
      end else begin
        word_n[i] = s_out[16*i +: 16];
        sat_n[i]  = sat[i];
      end
    end
  end

  // The buffer read port delivers its word one cycle after buf_ren, which is
  // the same cycle the registered write enables go high; the operand bus is
  // therefore the buffer's registered read data, gated to zero when no
  // enable is active so the bus stays quiet outside load cycles and reset.
  assign op_data = (awe0 || awe1 || bwe0 || bwe1) ? buf_rdata : 16'h0000;
  assign a_in0   = op_data;
  assign a_in1   = op_data;
  assign b_in0   = op_data;
  assign b_in1   = op_data;

  // Sequencer: state, counters, captures and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 8'd0;
      k         <= 8'd0;
      abase     <= '0;
      bbase     <= '0;
      sbase     <= '0;
      wcnt      <= '0;
      cap_flag  <= 4'd0;
      cap_sat   <= 4'd0;
      for (int i = 0; i < 4; i++) cap_val[i] <= 16'h0000;
      cmd_ready <= 1'b0;
      buf_ren   <= 1'b0;
      buf_radr  <= '0;
      buf_wen   <= 1'b0;
      buf_wadr  <= '0;
      buf_wdata <= 16'h0000;
      awe0      <= 1'b0;
      awe1      <= 1'b0;
      bwe0      <= 1'b0;
      bwe1      <= 1'b0;
      start     <= 1'b0;
      max_cntr  <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_len   <= 1'b0;
      err_sat   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      buf_ren <= 1'b0;
      buf_wen <= 1'b0;
      start   <= 1'b0;
      done    <= 1'b0;
      // Each read issued last cycle lands on its enable this cycle.
      awe0    <= buf_ren && (state == LD_A0);
      awe1    <= buf_ren && (state == LD_A1);
      bwe0    <= buf_ren && (state == LD_B0);
      bwe1    <= buf_ren && (state == LD_B1);

      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          max_cntr  <= 8'd0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            k         <= cmd_len;
            abase     <= cmd_abase;
            bbase     <= cmd_bbase;
            sbase     <= cmd_sbase;
            idx       <= 8'd0;
            wcnt      <= '0;
            cap_flag  <= 4'd0;
            cap_sat   <= 4'd0;
            for (int i = 0; i < 4; i++) cap_val[i] <= 16'h0000;
            err_len   <= 1'b0;
            err_sat   <= 1'b0;
            err_tmo   <= 1'b0;
            if (cmd_len == 8'd0) begin
              state   <= DONE;
              done    <= 1'b1;
              err_len <= 1'b1;
            end else begin
              state    <= LD_A0;
              buf_ren  <= 1'b1;
              buf_radr <= cmd_abase;
            end
          end
        end

        LD_A0, LD_A1, LD_B0, LD_B1: begin
          if (idx == k - 8'd1) begin
            idx <= 8'd0;
            case (state)
              LD_A0: begin
                state    <= LD_A1;
                buf_ren  <= 1'b1;
                buf_radr <= abase + k_adr;
              end
              LD_A1: begin
                state    <= LD_B0;
                buf_ren  <= 1'b1;
                buf_radr <= bbase;
              end
              LD_B0: begin
                state    <= LD_B1;
                buf_ren  <= 1'b1;
                buf_radr <= bbase + k_adr;
              end
              default: begin
                // Last B1 read is out; FLUSH carries its enable.
                state <= FLUSH;
              end
            endcase
          end else begin
            idx      <= idx + 8'd1;
            buf_ren  <= 1'b1;
            buf_radr <= buf_radr + ADR_W'(1);
          end
        end

        FLUSH: begin
          state    <= START;
          start    <= 1'b1;
          max_cntr <= k;
        end

        START: begin
          state <= WAIT;
          wcnt  <= '0;
        end

        WAIT: begin
          cap_flag <= flag_n;
          for (int i = 0; i < 4; i++) begin
            if (se[i] && !cap_flag[i]) begin
              cap_val[i] <= s_out[16*i +: 16];
              cap_sat[i] <= sat[i];
            end
          end
          if (&flag_n) begin
            state     <= STORE;
            idx       <= 8'd0;
            buf_wen   <= 1'b1;
            buf_wadr  <= sbase;
            buf_wdata <= word_n[0];
          end else if (wcnt == TW'(TMO - 1)) begin
            state    <= DONE;
            done     <= 1'b1;
            err_tmo  <= 1'b1;
            err_sat  <= |(sat_n & flag_n);
            max_cntr <= 8'd0;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end

        STORE: begin
          if (idx == 8'd3) begin
            state    <= DONE;
            done     <= 1'b1;
            err_sat  <= |cap_sat;
            max_cntr <= 8'd0;
          end else begin
            idx       <= idx + 8'd1;
            buf_wen   <= 1'b1;
            buf_wadr  <= buf_wadr + ADR_W'(1);
            buf_wdata <= cap_val[idx[1:0] + 2'd1];
          end
        end

        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          max_cntr  <= 8'd0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b0;
          max_cntr  <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq
//
// Directed bench for systolic_seq (ADR_W=12, TMO=8). A behavioural buffer
// returns mem[addr] one cycle after each read. Each scenario is checked cycle
// by cycle against a timeline derived from the command: reads on cycles
// 1..4K, FLUSH at 4K+1, start at 4K+2, WAIT from 4K+3, four writes after the
// last PE capture, done after those (or TMO cycles into WAIT on timeout).
// -----------------------------------------------------------------------------
module tb_systolic_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_len;
  logic [11:0] cmd_abase, cmd_bbase, cmd_sbase;
  logic        buf_ren, buf_wen;
  logic [11:0] buf_radr, buf_wadr;
  logic [15:0] buf_rdata, buf_wdata;
  logic [15:0] a_in0, a_in1, b_in0, b_in1;
  logic        awe0, awe1, bwe0, bwe1;
  logic        start;
  logic [7:0]  max_cntr;
  logic [3:0]  se, sat;
  logic [63:0] s_out;
  logic        busy, done, err_len, err_sat, err_tmo;

  logic [15:0] mem [4096];
  int          n_checks = 0;
  int          n_fails  = 0;

  always #5 clk = ~clk;

  systolic_seq #(.ADR_W(12), .TMO(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_abase(cmd_abase), .cmd_bbase(cmd_bbase), .cmd_sbase(cmd_sbase),
    .buf_ren(buf_ren), .buf_radr(buf_radr), .buf_rdata(buf_rdata),
    .buf_wen(buf_wen), .buf_wadr(buf_wadr), .buf_wdata(buf_wdata),
    .a_in0(a_in0), .a_in1(a_in1), .b_in0(b_in0), .b_in1(b_in1),
    .awe0(awe0), .awe1(awe1), .bwe0(bwe0), .bwe1(bwe1),
    .start(start), .max_cntr(max_cntr),
    .se(se), .sat(sat), .s_out(s_out),
    .busy(busy), .done(done),
    .err_len(err_len), .err_sat(err_sat), .err_tmo(err_tmo)
  );

  // Buffer model: registered read, data valid the cycle after buf_ren.
  always @(posedge clk) buf_rdata <= buf_ren ? mem[buf_radr] : 16'h0000;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_val({tag, "_ctl"}, {19'd0, buf_ren, buf_wen, awe0, awe1, bwe0, bwe1, start,
                            done, busy, cmd_ready, err_len, err_sat, err_tmo}, 32'd0);
    chk_val({tag, "_dat"}, {31'd0, |{buf_radr, buf_wadr, buf_wdata, a_in0, a_in1,
                                     b_in0, b_in1, max_cntr}}, 32'd0);
  endtask

  // Read address issued on cycle pc (1-based) for a command of length k.
  function automatic logic [11:0] exp_addr(input int k, input int ab, input int bb, input int pc);
    int p, i, base, off;
    p    = (pc - 1) / k;
    i    = (pc - 1) % k;
    base = (p < 2) ? ab : bb;
    off  = (p % 2 == 1) ? k : 0;
    return 12'((base + off + i) & 32'h0000_0FFF);
  endfunction

  // PE-side stimulus. scn 0: all se at cycle sc; scn 1: staggered with a
  // re-pulse and saturation on PE1_0; scn 2: se never arrives (sat noise).
  task automatic drive_pe(input int scn, input int c, input int w, input int sc,
                          input logic [63:0] words);
    se    = 4'h0;
    sat   = 4'h0;
    s_out = {4{16'hF000}};
    if (scn == 0) begin
      s_out = words;
      if (c == sc) se = 4'hF;
    end else if (scn == 1) begin
      case (c - w)
        1: begin se = 4'b0001; s_out[15:0]  = 16'h0A0A; end
        2: begin se = 4'b0010; s_out[31:16] = 16'h0B0B; sat = 4'b0010; end
        3: begin se = 4'b0101; s_out[15:0]  = 16'hDEAD; s_out[47:32] = 16'h0C0C; sat = 4'b0001; end
        5: begin se = 4'b1001; s_out[15:0]  = 16'hBEEF; s_out[63:48] = 16'h0D0D; end
        default: se = 4'h0;
      endcase
    end else begin
      sat = 4'hF;
    end
  endtask

  // One full command with per-cycle checks against the derived timeline.
  task automatic run_scn(input int scn, input int k, input int ab, input int bb, input int sb,
                         input int sc, input logic [63:0] words, input logic [2:0] errs,
                         input int hold_valid);
    int          w, td, j;
    logic [3:0]  exp_we;
    logic [5:0]  exp_ctl;
    logic        exp_ren, exp_wen;
    logic [15:0] exp_d;
    w  = 4 * k + 3;
    td = (scn == 2) ? w + 8 : sc + 5;
    chk_val("ready_c0", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = 8'(k);
    cmd_abase = 12'(ab);
    cmd_bbase = 12'(bb);
    cmd_sbase = 12'(sb);
    drive_pe(scn, 0, w, sc, words);
    for (int c = 1; c <= td + 2; c++) begin
      tick();
      if (c <= hold_valid) begin
        cmd_valid = 1'b1;
        cmd_len   = 8'd5;
        cmd_abase = 12'h123;
      end else begin
        cmd_valid = 1'b0;
      end
      drive_pe(scn, c, w, sc, words);

      exp_ren = (c <= 4 * k);
      exp_wen = (scn != 2) && (c >= sc + 1) && (c <= sc + 4);
      exp_ctl = {exp_ren, exp_wen, c == 4 * k + 2, c == td, c <= td, c > td};
      chk_val($sformatf("ctl_c%0d", c), {26'd0, buf_ren, buf_wen, start, done, busy, cmd_ready},
              {26'd0, exp_ctl});
      if (exp_ren)
        chk_val($sformatf("radr_c%0d", c), {20'd0, buf_radr}, {20'd0, exp_addr(k, ab, bb, c)});
      exp_we = 4'b0000;
      if (c >= 2 && c <= 4 * k + 1) exp_we = 4'b1000 >> ((c - 2) / k);
      chk_val($sformatf("we_c%0d", c), {28'd0, awe0, awe1, bwe0, bwe1}, {28'd0, exp_we});
      if (exp_we != 4'b0000) begin
        exp_d = mem[exp_addr(k, ab, bb, c - 1)];
        chk_val($sformatf("ain_c%0d", c), {a_in0, a_in1}, {exp_d, exp_d});
        chk_val($sformatf("bin_c%0d", c), {b_in0, b_in1}, {exp_d, exp_d});
      end
      if (exp_wen) begin
        j = c - sc - 1;
        chk_val($sformatf("wadr_c%0d", c), {20'd0, buf_wadr}, (sb + j) & 32'h0000_0FFF);
        chk_val($sformatf("wdata_c%0d", c), {16'd0, buf_wdata}, {16'd0, words[16*j +: 16]});
      end
      if (c < td)
        chk_val($sformatf("max_cntr_c%0d", c), {24'd0, max_cntr},
                (c >= 4 * k + 2) ? k : 0);
      chk_val($sformatf("errs_c%0d", c), {29'd0, err_len, err_sat, err_tmo},
              (c < td) ? 32'd0 : {29'd0, errs});
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'(a * 37 + 5);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_len   = 8'd0;
    cmd_abase = 12'h000;
    cmd_bbase = 12'h000;
    cmd_sbase = 12'h000;
    se        = 4'h0;
    sat       = 4'h0;
    s_out     = 64'd0;
    tick();
    tick();
    chk_all_zero("rst_init");
    rst = 1'b0;
    tick();
    chk_val("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Nominal K=3; cmd_valid held two extra cycles with other values.
    run_scn(0, 3, 32'h100, 32'h200, 32'h300, 20,
            {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 3'b000, 2);

    // K=0: done right after accept, err_len, no traffic.
    cmd_valid = 1'b1;
    cmd_len   = 8'd0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      cmd_valid = 1'b0;
      chk_val($sformatf("k0_ctl_c%0d", c), {26'd0, buf_ren, buf_wen, start, done, busy, cmd_ready},
              (c == 1) ? 32'b000110 : 32'b000001);
      chk_val($sformatf("k0_we_c%0d", c), {28'd0, awe0, awe1, bwe0, bwe1}, 32'd0);
      chk_val($sformatf("k0_errs_c%0d", c), {29'd0, err_len, err_sat, err_tmo}, 32'b100);
    end

    // Staggered se with re-pulse and saturation on PE1_0.
    run_scn(1, 1, 32'h010, 32'h020, 32'h030, 12,
            {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A}, 3'b010, 0);

    // Watchdog: se never arrives.
    run_scn(2, 1, 32'h040, 32'h050, 32'h060, 0, 64'd0, 3'b001, 0);

    // Read and write address wrap.
    run_scn(0, 2, 32'hFFE, 32'h500, 32'hFFE, 13,
            {16'h8888, 16'h7777, 16'h6666, 16'h5555}, 3'b000, 0);

    // Reset during LD_B0 (cycles 7..9 for K=3).
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    cmd_abase = 12'h700;
    cmd_bbase = 12'h800;
    cmd_sbase = 12'h900;
    for (int c = 1; c <= 8; c++) begin
      tick();
      cmd_valid = 1'b0;
    end
    chk_val("mid_radr", {20'd0, buf_radr}, 32'h801);
    rst = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    tick();
    chk_val("rst_mid_ready", {30'd0, cmd_ready, busy}, 32'b10);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_val($sformatf("rst_quiet_%0d", c), {28'd0, done, buf_ren, buf_wen, bwe1}, 32'd0);
    end

    // Fresh command after the abort; all se on the first WAIT cycle.
    run_scn(0, 3, 32'h0A0, 32'h0B0, 32'h0C0, 15,
            {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0}, 3'b000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/systolic_seq.md
SYSTOLIC_SEQ -- requirements
Module: systolic_seq

Interface
REQ-001 SHALL have parameter ADR_W, default 12, buffer word-address width.
REQ-002 SHALL have parameter TMO, default 1023, WAIT-state watchdog limit in cycles.
REQ-003 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: cmd_valid in 1 command request; cmd_ready out 1 high only in IDLE; cmd_len in 8 vector length K; cmd_abase, cmd_bbase, cmd_sbase in ADR_W A/B source and result bases.
REQ-006 SHALL have ports: buf_ren out 1; buf_radr out ADR_W; buf_rdata in 16, valid exactly 1 cycle after buf_ren.
REQ-007 SHALL have ports: buf_wen out 1; buf_wadr out ADR_W; buf_wdata out 16.
REQ-008 SHALL have ports: a_in0, a_in1, b_in0, b_in1 out 16; awe0, awe1, bwe0, bwe1 out 1; start out 1; max_cntr out 8.
REQ-009 SHALL have ports: se in 4 and sat in 4, bit order {PE1_1,PE0_1,PE1_0,PE0_0}; s_out in 64, same order, 16 bits per PE.
REQ-010 SHALL have ports: busy out 1; done out 1; err_len, err_sat, err_tmo out 1.

Function
REQ-011 SHALL use states IDLE, LD_A0, LD_A1, LD_B0, LD_B1, FLUSH, START, WAIT, STORE, DONE.
REQ-012 SHALL accept a command on cmd_valid & cmd_ready; latch K and bases; cmd_valid while not in IDLE ignored.
REQ-013 SHALL, when K=0, go IDLE->DONE directly: err_len=1, no buf_ren, no we, no start.
REQ-014 SHALL in each LD state issue K reads, one per cycle, buf_ren=1: LD_A0 abase+i, LD_A1 abase+K+i, LD_B0 bbase+i, LD_B1 bbase+K+i, i=0..K-1; addresses wrap modulo 2^ADR_W.
REQ-015 SHALL assert the matching we (awe0/awe1/bwe0/bwe1) exactly one cycle after each read, driving buf_rdata on the matching a_in/b_in; all four data outputs carry the same value.
REQ-016 SHALL use FLUSH as one cycle carrying the last bwe1 with no buf_ren.
REQ-017 SHALL in START assert start for exactly one cycle; max_cntr = K from START until DONE, 0 otherwise.
REQ-018 SHALL in WAIT capture each PE's s_out slice and sat bit on the first cycle its se bit is 1 (sticky per PE); a repeated se pulse does not recapture.
REQ-019 SHALL leave WAIT to STORE when all four captured flags are set, including same-cycle arrival.
REQ-020 SHALL, if WAIT lasts TMO cycles without all flags, set err_tmo and go to DONE, skipping STORE.
REQ-021 SHALL in STORE write 4 words, one per cycle, buf_wen=1, buf_wadr = sbase+0..3, order PE0_0, PE1_0, PE0_1, PE1_1.
REQ-022 SHALL set err_sat = OR of captured sat bits.
REQ-023 SHALL in DONE assert done for 1 cycle, then return to IDLE.
REQ-024 SHALL hold err_len, err_sat and err_tmo from DONE until the next command is accepted.
REQ-025 SHALL keep busy = 1 in every state except IDLE.
REQ-026 SHALL register all outputs; buf_ren and buf_wen are never high in the same cycle.

Reset
REQ-027 SHALL on rst=1 at a clock edge enter IDLE and clear all counters, captures and flags, including mid-command.
REQ-028 SHALL drive all outputs 0 while in reset, except cmd_ready, which is 1 from the first cycle after reset.
REQ-029 SHALL not complete in-flight reads or writes after reset, and SHALL not assert done for the aborted command.

Verification
REQ-030 SHALL cover nominal K=3 (accept at cycle 0): reads on cycles 1-12, start at cycle 14, max_cntr=3; se all high at cycle 20 -> writes sbase..sbase+3 on cycles 21-24, done at cycle 25.
REQ-031 SHALL cover K=0: done the cycle after accept with err_len=1, and zero buf_ren/we/start activity.
REQ-032 SHALL cover se bits arriving staggered and re-pulsed, with sat on PE1_0: first-capture values written and err_sat=1.
REQ-033 SHALL cover TMO=8 with se=0: err_tmo=1 and done 8 cycles after entering WAIT, with no buf_wen.
REQ-034 SHALL cover rst asserted during LD_B0: all outputs 0 next cycle, cmd_ready=1 after release, and a new command runs correctly.
REQ-035 SHALL cover abase=0xFFE, K=2: LD_A1 reads 0x000 and 0x001 (address wrap).
